// File: rtl/wave_capture.sv
// Scope-style capture buffer: arms, waits for a rising crossing of trig_level, stores 2^A_WIDTH samples.
// Optional WAVE_CAPTURE_TIMEOUT_EN forces a trigger after TO_COUNT accepted samples while armed.
module wave_capture #(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 8,
  parameter int TO_COUNT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic [D_WIDTH-1:0] trig_level,
  input  logic               arm,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic               forced_trig
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t             state, next;
  logic [D_WIDTH-1:0] mem [0:(2**A_WIDTH)-1];
  logic [D_WIDTH-1:0] prev;
  logic               prev_valid;
  logic [A_WIDTH-1:0] wptr;
  logic               real_trig, force_trig, trig, wr_en;
  logic [A_WIDTH-1:0] wr_addr;

  // arm while ARMED restarts the search, so it masks any trigger on that cycle
  always_comb begin
    real_trig = (state == S_ARMED) && !arm && en && prev_valid &&
                (prev < trig_level) && (din >= trig_level);
  end

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_COUNT) + 1;
  logic [CNT_W-1:0] to_cnt;

  always_comb begin
    force_trig = (state == S_ARMED) && !arm && en && !real_trig &&
                 (to_cnt == CNT_W'(TO_COUNT - 1));
  end
`else
  always_comb begin
    force_trig  = 1'b0;
    forced_trig = 1'b0;
  end
`endif

  always_comb begin
    trig    = real_trig || force_trig;
    wr_en   = trig || ((state == S_CAPTURE) && en);
    wr_addr = (state == S_CAPTURE) ? wptr : '0;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:    if (arm) next = S_ARMED;
      S_ARMED:   if (trig) next = S_CAPTURE;
      S_CAPTURE: if (en && (wptr == '1)) next = S_DONE;
      S_DONE:    if (arm) next = S_ARMED;
      default:   next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_data    <= '0;
      prev_valid <= 1'b0;
      wptr       <= '0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
      forced_trig <= 1'b0;
      to_cnt      <= '0;
`endif
    end else begin
      state   <= next;
      armed   <= (next == S_ARMED);
      busy    <= (next == S_CAPTURE);
      done    <= (next == S_DONE);
      rd_data <= mem[rd_addr];
      unique case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            prev_valid <= 1'b0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            forced_trig <= 1'b0;
            to_cnt      <= '0;
`endif
          end
        end
        S_ARMED: begin
          if (arm) begin
            prev_valid <= 1'b0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end else if (en) begin
            prev       <= din;
            prev_valid <= 1'b1;
            if (trig) wptr <= A_WIDTH'(1);
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            to_cnt <= to_cnt + 1'b1;
            if (force_trig) forced_trig <= 1'b1;
`endif
          end
        end
        S_CAPTURE: begin
          if (en) wptr <= wptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
